// File: rtl/frac_clk_gen.sv
// Fractional-N clock-enable generator: a phase accumulator produces a tick
// strobe and a ~50% clock_out at clock_in * inc / 2^ACC_W. The increment is
// reloaded at runtime through a valid/ready handshake. A lock monitor counts
// ticks after each reload, and a reset sequencer releases downstream logic a
// fixed number of cycles after lock.
module frac_clk_gen #(
  parameter int ACC_W       = 16,
  parameter int INC_DEFAULT = 16384,
  parameter int LOCK_CYCLES = 16,
  parameter int RST_HOLD    = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_valid,
  output logic             inc_ready,
  output logic             tick,
  output logic             clock_out,
  output logic             locked,
  output logic             reset_out
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [ACC_W-1:0] INC_RST = ACC_W'(INC_DEFAULT);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_LOCKED,
    ST_APPLY,
    ST_STOPPED
  } state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [ACC_W-1:0]   inc, inc_next;
  logic [LOCK_W-1:0]  lock_cnt, lock_cnt_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
  logic               tick_next, clock_out_next, locked_next, reset_out_next;
  logic [ACC_W:0]     acc_sum;
  logic               carry;
  logic               accept;

  // The block refuses new ratios while a reload is being applied or while
  // it is itself held in reset.
  assign inc_ready = (state != ST_APPLY) && !reset;
  assign accept    = inc_valid && inc_ready;
  assign acc_sum   = {1'b0, acc} + {1'b0, inc};
  assign carry     = acc_sum[ACC_W];

  // Next-state and datapath update; an accepted reload overrides any
  // same-cycle carry, and a disabled accumulator freezes but never ticks.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    inc_next       = inc;
    lock_cnt_next  = lock_cnt;
    hold_cnt_next  = hold_cnt;
    tick_next      = 1'b0;
    clock_out_next = clock_out;
    locked_next    = locked;
    reset_out_next = reset_out;

    if (accept) begin
      inc_next       = inc_in;
      acc_next       = '0;
      lock_cnt_next  = '0;
      hold_cnt_next  = '0;
      clock_out_next = 1'b0;
      locked_next    = 1'b0;
      reset_out_next = 1'b1;
      state_next     = ST_APPLY;
    end else begin
      case (state)
        ST_APPLY: begin
          state_next = (inc != '0) ? ST_SETTLE : ST_STOPPED;
        end
        ST_SETTLE: begin
          if (enable) begin
            acc_next       = acc_sum[ACC_W-1:0];
            tick_next      = carry;
            clock_out_next = acc_sum[ACC_W-1];
            if (carry) begin
              lock_cnt_next = lock_cnt + LOCK_W'(1);
              if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                locked_next = 1'b1;
                state_next  = ST_LOCKED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (hold_cnt != HOLD_W'(RST_HOLD)) begin
            hold_cnt_next = hold_cnt + HOLD_W'(1);
          end
          if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            reset_out_next = 1'b0;
          end
          if (enable) begin
            acc_next       = acc_sum[ACC_W-1:0];
            tick_next      = carry;
            clock_out_next = acc_sum[ACC_W-1];
          end
        end
        default: begin
          clock_out_next = 1'b0;
          locked_next    = 1'b0;
          reset_out_next = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset to the default ratio.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= (INC_RST == '0) ? ST_STOPPED : ST_SETTLE;
      acc       <= '0;
      inc       <= INC_RST;
      lock_cnt  <= '0;
      hold_cnt  <= '0;
      tick      <= 1'b0;
      clock_out <= 1'b0;
      locked    <= 1'b0;
      reset_out <= 1'b1;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      inc       <= inc_next;
      lock_cnt  <= lock_cnt_next;
      hold_cnt  <= hold_cnt_next;
      tick      <= tick_next;
      clock_out <= clock_out_next;
      locked    <= locked_next;
      reset_out <= reset_out_next;
    end
  end

endmodule
